// File: rtl/calc_keypad_engine.sv
// Keypad calculator core: NDIG-digit decimal operands, + - x with sign, chaining,
// clear and error state; results go to BCD through a serial shift-add-3 converter.
module calc_keypad_engine #(
   parameter int NDIG = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_key,
   output logic [8*NDIG-1:0] o_disp,
   output logic [2*NDIG-1:0] o_blank,
   output logic              o_neg,
   output logic              o_err,
   output logic              o_busy
);
   localparam int DDIG = 2*NDIG;
   localparam int DW   = 4*DDIG;
   localparam int RW   = $clog2(10**DDIG);
   localparam int AW   = $clog2(10**NDIG);
   localparam int CW   = $clog2(NDIG+1);
   localparam int KW   = $clog2(RW+1);
   localparam logic [CW-1:0] NDIG_C = CW'(NDIG);
   localparam logic [RW-1:0] LIM    = RW'(10**NDIG);

   typedef enum logic [2:0] {S_ENT_A, S_ENT_B, S_CONV, S_SHOW, S_ERR} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

   state_t          r_state, w_state;
   op_t             r_op, w_op, w_key_op;
   logic [AW-1:0]   r_a, w_a, r_b, w_b;
   logic [CW-1:0]   r_cnt_a, w_cnt_a, r_cnt_b, w_cnt_b;
   logic [RW-1:0]   r_r, w_r, r_sh, w_sh;
   logic            r_neg_r, w_neg_r;
   logic [DW-1:0]   r_bcd, w_bcd;
   logic [KW-1:0]   r_cyc, w_cyc;
   logic [DW-1:0]   r_disp, w_disp;
   logic [DDIG-1:0] r_blank, w_blank;
   logic            r_neg, w_neg, r_err, w_err, r_busy, w_busy;
   logic [7:0]      r_key_prev;
   logic            w_press, w_is_dig, w_is_op, w_is_eq, w_clr;
   logic [3:0]      w_dig;
   logic [RW-1:0]   w_ra, w_rb;

   // Blank every position at or above max(n,1) while an operand is being typed.
   function automatic logic [DDIG-1:0] cnt_blank(input logic [CW-1:0] n);
      int lit;
      lit = (n == '0) ? 1 : int'(n);
      for (int i = 0; i < DDIG; i++) cnt_blank[i] = (i >= lit);
   endfunction

   function automatic logic [DDIG-1:0] bcd_blank(input logic [DW-1:0] bcd);
      logic lead;
      lead = 1'b1;
      bcd_blank = '0;
      for (int i = DDIG-1; i > 0; i--) begin
         if (bcd[4*i +: 4] != 4'd0) lead = 1'b0;
         bcd_blank[i] = lead;
      end
   endfunction

   function automatic logic [DW-1:0] dabble(input logic [DW-1:0] bcd, input logic bin);
      logic [DW-1:0] t;
      t = bcd;
      for (int i = 0; i < DDIG; i++)
         if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      return {t[DW-2:0], bin};
   endfunction

   assign w_press  = (i_key != 8'hFF) && (r_key_prev == 8'hFF);
   assign w_is_dig = w_press && (i_key <= 8'h09);
   assign w_is_op  = w_press && (i_key == 8'h0A || i_key == 8'h0B || i_key == 8'h0C);
   assign w_is_eq  = w_press && (i_key == 8'h0E);
   assign w_dig    = i_key[3:0];
   assign w_ra     = RW'(r_a);
   assign w_rb     = RW'(r_b);

   always_comb begin
      w_key_op = OP_ADD;
      if (i_key[1:0] == 2'b11)      w_key_op = OP_SUB;
      else if (i_key[1:0] == 2'b00) w_key_op = OP_MUL;
   end

   always_comb begin
      w_state = r_state;  w_op = r_op;  w_a = r_a;  w_b = r_b;
      w_cnt_a = r_cnt_a;  w_cnt_b = r_cnt_b;  w_r = r_r;  w_sh = r_sh;
      w_neg_r = r_neg_r;  w_bcd = r_bcd;  w_cyc = r_cyc;  w_disp = r_disp;
      w_blank = r_blank;  w_neg = r_neg;  w_err = r_err;  w_busy = r_busy;
      w_clr   = w_press && (i_key == 8'h0F);
      case (r_state)
         S_ENT_A: begin
            if (w_is_dig && r_cnt_a < NDIG_C) begin
               w_a     = (r_cnt_a == '0) ? AW'(w_dig) : r_a * AW'(10) + AW'(w_dig);
               w_cnt_a = r_cnt_a + CW'(1);
               w_disp  = (r_cnt_a == '0) ? DW'(w_dig) : ((r_disp << 4) | DW'(w_dig));
               w_blank = cnt_blank(r_cnt_a + CW'(1));
            end else if (w_is_op && r_cnt_a != '0) begin
               w_op = w_key_op;  w_b = '0;  w_cnt_b = '0;  w_state = S_ENT_B;
            end
         end
         S_ENT_B: begin
            if (w_is_dig && r_cnt_b < NDIG_C) begin
               w_b     = (r_cnt_b == '0) ? AW'(w_dig) : r_b * AW'(10) + AW'(w_dig);
               w_cnt_b = r_cnt_b + CW'(1);
               w_disp  = (r_cnt_b == '0) ? DW'(w_dig) : ((r_disp << 4) | DW'(w_dig));
               w_blank = cnt_blank(r_cnt_b + CW'(1));
            end else if (w_is_op && r_cnt_b == '0) begin
               w_op = w_key_op;
            end else if (w_is_eq && r_cnt_b != '0) begin
               w_neg_r = 1'b0;
               case (r_op)
                  OP_MUL:  w_r = w_ra * w_rb;
                  OP_SUB:  begin
                     if (w_ra >= w_rb) w_r = w_ra - w_rb;
                     else begin
                        w_r     = w_rb - w_ra;
                        w_neg_r = 1'b1;
                     end
                  end
                  default: w_r = w_ra + w_rb;
               endcase
               w_sh = w_r;  w_bcd = '0;  w_cyc = '0;  w_busy = 1'b1;  w_state = S_CONV;
            end
         end
         S_CONV: begin
            w_bcd = dabble(r_bcd, r_sh[RW-1]);
            w_sh  = r_sh << 1;
            w_cyc = r_cyc + KW'(1);
            if (r_cyc == KW'(RW-1)) begin
               w_disp  = w_bcd;
               w_blank = bcd_blank(w_bcd);
               w_neg   = r_neg_r;
               w_busy  = 1'b0;
               w_state = S_SHOW;
            end
         end
         S_SHOW: begin
            if (w_is_dig) begin
               w_a = AW'(w_dig);  w_cnt_a = CW'(1);  w_b = '0;  w_cnt_b = '0;
               w_neg = 1'b0;  w_disp = DW'(w_dig);  w_blank = cnt_blank(CW'(1));
               w_state = S_ENT_A;
            end else if (w_is_op) begin
               // Chaining only works while the result still fits one operand.
               if (!r_neg && r_r < LIM) begin
                  w_a = AW'(r_r);  w_cnt_a = NDIG_C;  w_op = w_key_op;
                  w_b = '0;  w_cnt_b = '0;  w_state = S_ENT_B;
               end else begin
                  w_err = 1'b1;  w_blank = '1;  w_neg = 1'b0;  w_state = S_ERR;
               end
            end
         end
         S_ERR:   ;
         default: w_clr = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_key_prev <= 8'hFF;
      else       r_key_prev <= i_key;
      if (i_rst || w_clr) begin
         r_state <= S_ENT_A;  r_op <= OP_ADD;  r_a <= '0;  r_b <= '0;
         r_cnt_a <= '0;  r_cnt_b <= '0;  r_r <= '0;  r_sh <= '0;  r_neg_r <= 1'b0;
         r_bcd <= '0;  r_cyc <= '0;  r_disp <= '0;
         r_blank <= {{(DDIG-1){1'b1}}, 1'b0};
         r_neg <= 1'b0;  r_err <= 1'b0;  r_busy <= 1'b0;
      end else begin
         r_state <= w_state;  r_op <= w_op;  r_a <= w_a;  r_b <= w_b;
         r_cnt_a <= w_cnt_a;  r_cnt_b <= w_cnt_b;  r_r <= w_r;  r_sh <= w_sh;
         r_neg_r <= w_neg_r;  r_bcd <= w_bcd;  r_cyc <= w_cyc;  r_disp <= w_disp;
         r_blank <= w_blank;  r_neg <= w_neg;  r_err <= w_err;  r_busy <= w_busy;
      end
   end

   assign o_disp  = r_disp;
   assign o_blank = r_blank;
   assign o_neg   = r_neg;
   assign o_err   = r_err;
   assign o_busy  = r_busy;
endmodule

// File: tb/tb_calc_keypad_engine.sv
// Directed bench for calc_keypad_engine (NDIG=2): keys are typed as short strings,
// outputs sampled on the falling edge against hand-computed values.
module tb_calc_keypad_engine;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  key;
   logic [15:0] disp;
   logic [3:0]  blank;
   logic        neg, err, busy;
   int          n_checks = 0;
   int          n_fail   = 0;

   calc_keypad_engine #(.NDIG(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_key(key), .o_disp(disp),
      .o_blank(blank), .o_neg(neg), .o_err(err), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] d, input logic [3:0] b,
                          input logic n);
      check({tag, "_disp"},  32'(disp),  32'(d));
      check({tag, "_blank"}, 32'(blank), 32'(b));
      check({tag, "_neg"},   32'(neg),   32'(n));
   endtask

   task automatic press(input logic [7:0] k);
      @(negedge clk) key = k;
      @(negedge clk) key = 8'hFF;
   endtask

   task automatic wait_conv();
      int n;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(n), 32'd14);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("conv_done", 32'(busy), 32'd0);
   endtask

   // '=' waits out the conversion; 'e' sends the same key without waiting.
   task automatic seq(input string s);
      logic [7:0] c, k;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         case (c)
            "+":     k = 8'h0A;
            "-":     k = 8'h0B;
            "x":     k = 8'h0C;
            "=":     k = 8'h0E;
            "e":     k = 8'h0E;
            "C":     k = 8'h0F;
            default: k = c - 8'h30;
         endcase
         press(k);
         if (c == "=") wait_conv();
      end
   endtask

   task automatic pulse_rst();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      key = 8'hFF;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_out("reset", 16'h0000, 4'b1110, 1'b0);
      check("reset_err",  32'(err),  32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      seq("12");   chk_out("entA_12", 16'h0012, 4'b1100, 1'b0);
      seq("+");    chk_out("op_keepA", 16'h0012, 4'b1100, 1'b0);
      seq("3");    chk_out("entB_3", 16'h0003, 4'b1110, 1'b0);
      seq("4=");   chk_out("add_46", 16'h0046, 4'b1100, 1'b0);

      seq("0");    chk_out("new_0", 16'h0000, 4'b1110, 1'b0);
      seq("5-12="); chk_out("sub_neg7", 16'h0007, 4'b1110, 1'b1);
      seq("99x99="); chk_out("mul_9801", 16'h9801, 4'b0000, 1'b0);

      seq("C123"); chk_out("third_digit", 16'h0012, 4'b1100, 1'b0);

      seq("C");
      @(negedge clk) key = 8'h07;
      repeat (5) @(negedge clk);
      key = 8'hFF;
      @(negedge clk);
      chk_out("held_key", 16'h0007, 4'b1110, 1'b0);
      seq("8");    chk_out("after_held", 16'h0078, 4'b1100, 1'b0);

      seq("C12+34=+");
      chk_out("chain_keep", 16'h0046, 4'b1100, 1'b0);
      check("chain_err", 32'(err), 32'd0);
      seq("1");    chk_out("chain_B", 16'h0001, 4'b1110, 1'b0);
      seq("=");    chk_out("chain_47", 16'h0047, 4'b1100, 1'b0);

      seq("C12x34="); chk_out("mul_408", 16'h0408, 4'b1000, 1'b0);
      seq("+");
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_blank", 32'(blank), 32'hF);
      seq("5");    check("err_sticky", 32'(err), 32'd1);
      seq("C");    chk_out("err_clear", 16'h0000, 4'b1110, 1'b0);
      check("err_clear_err", 32'(err), 32'd0);

      seq("01-02="); chk_out("sub_neg1", 16'h0001, 4'b1110, 1'b1);
      seq("+");
      check("neg_err", 32'(err), 32'd1);
      check("neg_err_neg", 32'(neg), 32'd0);
      seq("C");    check("neg_err_clear", 32'(err), 32'd0);

      seq("9+-3="); chk_out("op_replace", 16'h0006, 4'b1110, 1'b0);
      seq("C+5x3="); chk_out("op_noA", 16'h0015, 4'b1100, 1'b0);
      seq("e");
      check("eq_show_busy", 32'(busy), 32'd0);
      check("eq_show_disp", 32'(disp), 32'h0015);

      seq("C1+2e");
      check("conv_busy", 32'(busy), 32'd1);
      seq("5");
      wait_idle();
      chk_out("conv_ignore", 16'h0003, 4'b1110, 1'b0);

      seq("C1+2e");
      seq("C");
      check("conv_clr_busy", 32'(busy), 32'd0);
      chk_out("conv_clr", 16'h0000, 4'b1110, 1'b0);
      repeat (20) @(negedge clk);
      check("conv_clr_late", 32'(disp), 32'h0000);

      seq("4+5");
      pulse_rst();
      chk_out("rst_entB", 16'h0000, 4'b1110, 1'b0);
      seq("e");
      check("rst_eq_busy", 32'(busy), 32'd0);
      seq("2+1=");  chk_out("rst_after", 16'h0003, 4'b1110, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
